// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the memory read arbiter.
package mem_read_arbiter_pkg;

    localparam int NUM_REQ_DEF = 4;

    // Requester slots
    localparam int ICACHE_MEM  = 0;
    localparam int ICACHE_MMIO = 1;
    localparam int DCACHE_MEM  = 2;
    localparam int DCACHE_MMIO = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_t;

endpackage

// File: rtl/mem_read_arbiter_rr_arbiter.sv
// Combinational round-robin picker: scans requests starting at the pointer.
module rr_arbiter #(
    parameter int N   = 4,
    parameter int IDW = 2
) (
    input  logic [N-1:0]   i_req,
    input  logic [IDW-1:0] i_ptr,
    output logic [N-1:0]   o_gnt,
    output logic [IDW-1:0] o_idx,
    output logic           o_any
);

    logic [IDW-1:0] w_k;

    // First asserted request at or after the pointer, wrapping at N
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        o_any = 1'b0;
        w_k   = i_ptr;
        for (int i = 0; i < N; i++) begin
            if (!o_any && i_req[w_k]) begin
                o_any      = 1'b1;
                o_gnt[w_k] = 1'b1;
                o_idx      = w_k;
            end
            w_k = (w_k == IDW'(N - 1)) ? '0 : w_k + 1'b1;
        end
    end

endmodule

// File: rtl/mem_read_arbiter.sv
// Single-outstanding read arbiter between cache requesters and memory.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | no transaction; grant a requester round-robin this cycle
// ADDR    | presenting latched request downstream, waiting for ready
// DATA    | routing read beats to the owner until mem_rdata_last
module mem_read_arbiter
    import mem_read_arbiter_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEF,
    parameter int LEN_W   = 8,
    localparam int IDW    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ-1:0][31:0]       req_addr,
    input  logic [NUM_REQ-1:0][LEN_W-1:0]  req_len,
    input  logic [NUM_REQ-1:0]             req_drop,
    output logic                           mem_req_valid,
    input  logic                           mem_req_ready,
    output logic [31:0]                    mem_req_addr,
    output logic [LEN_W-1:0]               mem_req_len,
    output logic [IDW-1:0]                 mem_req_id,
    input  logic                           mem_rdata_valid,
    input  logic [31:0]                    mem_rdata,
    input  logic                           mem_rdata_last,
    output logic [NUM_REQ-1:0]             resp_valid,
    output logic [31:0]                    resp_data,
    output logic                           resp_last,
    output logic                           proto_err
);

    arb_state_t         r_state, w_state_nxt;
    logic [IDW-1:0]     r_rr_ptr;
    logic [IDW-1:0]     r_id;
    logic [31:0]        r_addr;
    logic [LEN_W-1:0]   r_len;
    logic [LEN_W-1:0]   r_cnt;
    logic               r_drop;
    logic               r_proto_err;

    logic [NUM_REQ-1:0] w_gnt;
    logic [IDW-1:0]     w_idx;
    logic               w_any;
    logic               w_beat;
    logic               w_deliver;
    logic               w_err;
    logic [NUM_REQ-1:0] w_id_oh;

    rr_arbiter #(.N(NUM_REQ), .IDW(IDW)) u_rr (
        .i_req (req_valid),
        .i_ptr (r_rr_ptr),
        .o_gnt (w_gnt),
        .o_idx (w_idx),
        .o_any (w_any)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next state, beat routing and error detection
    always_comb begin
        w_state_nxt   = r_state;
        req_ready     = '0;
        w_id_oh       = '0;
        w_id_oh[r_id] = 1'b1;
        w_beat        = (r_state == ST_DATA) && mem_rdata_valid;
        // a drop in the same cycle as a beat already suppresses it
        w_deliver     = w_beat && !r_drop && !req_drop[r_id];
        w_err         = (mem_rdata_valid && (r_state != ST_DATA)) ||
                        (w_beat && (mem_rdata_last != (r_cnt == r_len)));
        case (r_state)
            ST_IDLE: begin
                // reset is async, so gate the combinational grant with it too
                if (w_any && !rst) begin
                    req_ready   = w_gnt;
                    w_state_nxt = ST_ADDR;
                end
            end
            ST_ADDR: if (mem_req_ready) w_state_nxt = ST_DATA;
            ST_DATA: if (w_beat && mem_rdata_last) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
        mem_req_valid = (r_state == ST_ADDR);
        mem_req_addr  = r_addr;
        mem_req_len   = r_len;
        mem_req_id    = r_id;
        resp_valid    = w_deliver ? w_id_oh : '0;
        resp_data     = mem_rdata;
        resp_last     = w_deliver && mem_rdata_last;
        proto_err     = r_proto_err;
    end

    // Latched request, beat counter, drop flag, pointer and sticky error
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_id        <= '0;
            r_addr      <= '0;
            r_len       <= '0;
            r_cnt       <= '0;
            r_drop      <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            if (w_err) r_proto_err <= 1'b1;
            case (r_state)
                ST_IDLE: begin
                    r_cnt  <= '0;
                    r_drop <= 1'b0;
                    if (w_any) begin
                        r_addr <= req_addr[w_idx];
                        r_len  <= req_len[w_idx];
                        r_id   <= w_idx;
                    end
                end
                ST_ADDR: if (req_drop[r_id]) r_drop <= 1'b1;
                ST_DATA: begin
                    if (req_drop[r_id]) r_drop <= 1'b1;
                    if (w_beat) begin
                        if (mem_rdata_last) begin
                            r_cnt    <= '0;
                            r_drop   <= 1'b0;
                            r_rr_ptr <= (r_id == IDW'(NUM_REQ - 1)) ? '0 : r_id + 1'b1;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
